// File: rtl/nh_lcd_cmd_sequencer.sv
// Runs one LCD transaction through the single-byte command engine: a command byte,
// then buffered parameter writes and collected parameter reads, with gap and timeout control.
module nh_lcd_cmd_sequencer #(
  parameter int ADDR_BITS      = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic                 i_wbuf_stb,
  input  logic [7:0]           i_wbuf_data,
  input  logic                 i_wbuf_clear,
  input  logic [7:0]           i_cmd_byte,
  input  logic [ADDR_BITS-1:0] i_wr_count,
  input  logic [ADDR_BITS-1:0] i_rd_count,
  input  logic                 i_start_stb,
  input  logic [ADDR_BITS-1:0] i_rbuf_addr,
  output logic [7:0]           o_rbuf_data,
  output logic [ADDR_BITS:0]   o_wbuf_count,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic                 o_cmd_write_stb,
  output logic                 o_cmd_read_stb,
  output logic [7:0]           o_cmd_data,
  output logic                 o_cmd_parameter,
  input  logic                 i_cmd_finished,
  input  logic [7:0]           i_cmd_data,
  output logic [2:0]           o_dbg_state
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW    = $clog2(GAP_CYCLES + 2);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEND_CMD = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_SEND_WR  = 3'd4;
  localparam logic [2:0] S_SEND_RD  = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [ADDR_BITS:0]   WBUF_FULL = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   WC_ONE    = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE   = ADDR_BITS'(1);
  localparam logic [TW-1:0]        TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]        TMR_ONE   = TW'(1);
  localparam logic [GW-1:0]        GAP_LAST  = GW'(GAP_CYCLES);
  localparam logic [GW-1:0]        GAP_ONE   = GW'(1);

  logic [2:0]           state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 wr_stb_q, wr_stb_d;
  logic                 rd_stb_q, rd_stb_d;
  logic [7:0]           cmd_data_q, cmd_data_d;
  logic                 param_q, param_d;
  logic [ADDR_BITS:0]   wcount_q, wcount_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [ADDR_BITS-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_BITS-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_BITS-1:0] wptr_q, wptr_d;
  logic [ADDR_BITS-1:0] rptr_q, rptr_d;
  logic                 op_rd_q, op_rd_d;
  logic                 ok_q, ok_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [7:0]           rbuf_data_q;
  logic                 wbuf_we;
  logic                 rbuf_we;

  logic [7:0] wbuf_mem [DEPTH];
  logic [7:0] rbuf_mem [DEPTH];

  // Engine handshake: a strobe is a one-cycle request; i_cmd_finished completes it and is
  // only honoured in WAIT, so exactly one request is ever outstanding.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    wr_stb_d   = 1'b0;
    rd_stb_d   = 1'b0;
    cmd_data_d = cmd_data_q;
    param_d    = param_q;
    wcount_d   = wcount_q;
    cmd_d      = cmd_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    op_rd_d    = op_rd_q;
    ok_d       = ok_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    wbuf_we    = 1'b0;
    rbuf_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start_stb) begin
          if (i_enable && ({1'b0, i_wr_count} <= wcount_q)) begin
            error_d  = 1'b0;
            cmd_d    = i_cmd_byte;
            wr_cnt_d = i_wr_count;
            rd_cnt_d = i_rd_count;
            wptr_d   = '0;
            rptr_d   = '0;
            ok_d     = 1'b0;
            busy_d   = 1'b1;
            state_d  = S_SEND_CMD;
          end else begin
            error_d = 1'b1;
          end
        end
        if (i_wbuf_clear) begin
          wcount_d = '0;
        end else if (i_wbuf_stb) begin
          if (wcount_q < WBUF_FULL) begin
            wbuf_we  = 1'b1;
            wcount_d = wcount_q + WC_ONE;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_SEND_CMD: begin
        wr_stb_d   = 1'b1;
        param_d    = 1'b0;
        cmd_data_d = cmd_q;
        op_rd_d    = 1'b0;
        timer_d    = '0;
        state_d    = S_WAIT;
      end
      S_SEND_WR: begin
        wr_stb_d   = 1'b1;
        param_d    = 1'b1;
        cmd_data_d = wbuf_mem[wptr_q];
        wptr_d     = wptr_q + PTR_ONE;
        op_rd_d    = 1'b0;
        timer_d    = '0;
        state_d    = S_WAIT;
      end
      S_SEND_RD: begin
        rd_stb_d = 1'b1;
        param_d  = 1'b1;
        op_rd_d  = 1'b1;
        timer_d  = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (i_cmd_finished) begin
          if (op_rd_q) begin
            rbuf_we = 1'b1;
            rptr_d  = rptr_q + PTR_ONE;
          end
          gap_d   = '0;
          state_d = S_GAP;
        end else if (timer_q == TMO_LAST) begin
          error_d = 1'b1;
          ok_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      S_GAP: begin
        if (!i_enable) begin
          error_d = 1'b1;
          ok_d    = 1'b0;
          state_d = S_DONE;
        end else if (gap_q == GAP_LAST) begin
          if (wptr_q != wr_cnt_q) begin
            state_d = S_SEND_WR;
          end else if (rptr_q != rd_cnt_q) begin
            state_d = S_SEND_RD;
          end else begin
            ok_d    = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      S_DONE: begin
        busy_d   = 1'b0;
        done_d   = ok_q;
        wcount_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      cmd_data_q  <= '0;
      param_q     <= 1'b0;
      wcount_q    <= '0;
      cmd_q       <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      op_rd_q     <= 1'b0;
      ok_q        <= 1'b0;
      timer_q     <= '0;
      gap_q       <= '0;
      rbuf_data_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      wr_stb_q    <= wr_stb_d;
      rd_stb_q    <= rd_stb_d;
      cmd_data_q  <= cmd_data_d;
      param_q     <= param_d;
      wcount_q    <= wcount_d;
      cmd_q       <= cmd_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      op_rd_q     <= op_rd_d;
      ok_q        <= ok_d;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
      rbuf_data_q <= rbuf_mem[i_rbuf_addr];
    end
  end

  // Write-buffer contents need no reset: only bytes below the count are ever sent.
  always_ff @(posedge clk) begin
    if (wbuf_we) wbuf_mem[wcount_q[ADDR_BITS-1:0]] <= i_wbuf_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rbuf_mem[i] <= '0;
    end else if (rbuf_we) begin
      rbuf_mem[rptr_q] <= i_cmd_data;
    end
  end

  assign o_rbuf_data     = rbuf_data_q;
  assign o_wbuf_count    = wcount_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_error         = error_q;
  assign o_cmd_write_stb = wr_stb_q;
  assign o_cmd_read_stb  = rd_stb_q;
  assign o_cmd_data      = cmd_data_q;
  assign o_cmd_parameter = param_q;
  assign o_dbg_state     = state_q;

endmodule
